onehot_rr_arbiter: RTL and testbench
====================================

# onehot_rr_arbiter

Round-robin arbiter sharing one resource among 16 requesters. It produces a registered one-hot grant vector plus its binary index, so downstream logic can use either encoding. Each grant is held until the requester releases or a programmable hold limit expires, then the next requester is chosen. It sits in front of the binary-to-one-hot datapath and sequences which of the 16 lines is active.

## Interface
- MAX_HOLD, 8, maximum consecutive cycles a grant is held; legal range 1..255
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- en  input  1  arbitration enable; when low, no new grant is issued (an active grant is unaffected)
- req  input  16  request lines; bit i high means requester i wants the resource
- gnt  output  16  one-hot grant; all-zero when idle
- gnt_idx  output  4  binary index of the granted requester; holds its last value when idle
- gnt_valid  output  1  high when gnt is non-zero
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit

## Operation
- Internal state: FSM {IDLE, BUSY}, 4-bit priority pointer ptr, 8-bit hold counter hcnt.
- Reset (rst_n low at a clk edge, regardless of state or req):
  - state=IDLE, ptr=0, hcnt=0.
  - gnt=16'h0000, gnt_idx=4'h0, gnt_valid=0, timeout=0.
- IDLE:
  - If en=1 and req!=0, select the first set bit searching circularly from ptr upward: ptr, ptr+1, … 15, 0, … ptr-1.
  - Register gnt=1<<sel, gnt_idx=sel, gnt_valid=1, hcnt=0, and go to BUSY.
  - Otherwise stay in IDLE with gnt=0.
- BUSY, at each edge:
  - If req[gnt_idx]=0 (release): go to IDLE, gnt=0, gnt_valid=0, ptr=gnt_idx+1 (mod 16, so 15 wraps to 0), timeout=0.
  - Else if hcnt==MAX_HOLD-1 (limit reached): same actions as release, but timeout=1.
  - Else: hcnt=hcnt+1 and the grant is held.
- Release takes priority over timeout: if req drops on the same edge the limit is reached, timeout=0.
- Changes on req bits other than gnt_idx have no effect during BUSY.
- en is ignored in BUSY.
- timeout is high for exactly one cycle and is cleared at the next edge.
- gnt is one-hot or zero at all times. gnt_valid always equals |gnt.

## Timing
- Grant latency: req sampled at edge k in IDLE; gnt is visible after edge k (1 cycle).
- Minimum grant length is 1 cycle. Maximum is MAX_HOLD cycles.
- Exactly one dead cycle (gnt=0) follows every grant, including back-to-back re-grants to the same requester.
- Full-contention period is MAX_HOLD+1 cycles per requester.
- A requester that loses arbitration waits at most 15×(MAX_HOLD+1) cycles.
- A new grant decision uses the updated ptr from the previous grant's exit edge.
- Reset mid-BUSY: gnt=0 after the reset edge; the first grant after reset release searches from index 0.

## Test plan
- Reset: req=16'hFFFF, en=1, rst_n=0 for 3 cycles -> gnt=0, gnt_valid=0, gnt_idx=0, timeout=0 throughout. After rst_n=1, gnt=16'h0001 one cycle later.
- Hold limit (MAX_HOLD=4): req=16'h0008 held -> gnt=16'h0008, gnt_idx=3 for 4 cycles; then 1 cycle with gnt=0 and timeout=1; then gnt=16'h0008 again (search wraps from ptr=4 back to 3).
- Full rotation (MAX_HOLD=4): req=16'hFFFF held -> gnt_idx sequence 0,1,2,…,15,0. Each grant lasts 4 cycles with 1 dead cycle between; timeout pulses after each grant.
- Early release: req=16'h0021 -> idx 0 granted. Drop req[0] during the 2nd grant cycle -> gnt=16'h0001 for exactly 2 cycles, timeout=0, dead cycle, then gnt=16'h0020 (idx 5).
- Wrap and simultaneous events: after a grant to idx 15 (ptr becomes 0), req=16'h8001 -> next gnt_idx=0. Drop req[0] on the same edge hcnt reaches MAX_HOLD-1 -> timeout stays 0.
- Enable and mid-grant reset: en=0 with req=16'h0100 -> gnt stays 0; set en=1 -> gnt=16'h0100 next cycle. Then pull rst_n low during BUSY -> gnt=0, gnt_idx=0 after that edge.

Source files
------------

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter for 16 requesters with a registered one-hot grant,
// its binary index, and a hold-limit timeout pulse.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant active; search from ptr when en is high and req != 0
// BUSY  | grant active; held until release or hold limit reached
module onehot_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] req,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_idx,
  output logic        gnt_valid,
  output logic        timeout
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [7:0]  hcnt_q, hcnt_d;
  logic [15:0] gnt_d;
  logic [3:0]  idx_d;
  logic        valid_d;
  logic        timeout_d;

  logic [3:0]  sel;
  logic [3:0]  cand;
  logic        found;

  // Circular first-set search starting at ptr and wrapping through 15 to 0.
  always_comb begin
    sel   = 4'h0;
    cand  = 4'h0;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cand = ptr_q + 4'(i);
      if (!found && req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  // Next-state and next-output decisions; grant outputs are all registered.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hcnt_d    = hcnt_q;
    gnt_d     = gnt;
    idx_d     = gnt_idx;
    valid_d   = gnt_valid;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d   = 16'h0000;
        valid_d = 1'b0;
        if (en && found) begin
          gnt_d   = 16'h0001 << sel;
          idx_d   = sel;
          valid_d = 1'b1;
          hcnt_d  = 8'h00;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!req[gnt_idx] || (hcnt_q == HOLD_LAST)) begin
          // Release wins over the hold limit, so timeout only fires while
          // the owner is still requesting.
          state_d   = IDLE;
          gnt_d     = 16'h0000;
          valid_d   = 1'b0;
          ptr_d     = gnt_idx + 4'h1;
          timeout_d = req[gnt_idx];
        end else begin
          hcnt_d = hcnt_q + 8'h01;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 16'h0000;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 4'h0;
      hcnt_q    <= 8'h00;
      gnt       <= 16'h0000;
      gnt_idx   <= 4'h0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hcnt_q    <= hcnt_d;
      gnt       <= gnt_d;
      gnt_idx   <= idx_d;
      gnt_valid <= valid_d;
      timeout   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Directed bench for onehot_rr_arbiter with MAX_HOLD=4: a vector table
// covering reset, hold limit, release, wrap, enable and mid-grant reset,
// followed by a full-contention rotation sequence.
module tb_onehot_rr_arbiter;

  localparam int MH = 4;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] req;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic        timeout;

  int n_checks = 0;
  int n_fail   = 0;

  onehot_rr_arbiter #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are applied for the coming edge; expected values are the
  // outputs visible after that edge.
  typedef struct {
    logic        rst_n;
    logic        en;
    logic [15:0] req;
    logic [15:0] gnt;
    logic [3:0]  idx;
    logic        valid;
    logic        tmo;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic e, logic [15:0] q,
                              logic [15:0] g, logic [3:0] i, logic v, logic t);
    vec_t x;
    x.rst_n = r; x.en = e; x.req = q;
    x.gnt = g; x.idx = i; x.valid = v; x.tmo = t;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge, sample 1ns later, and check the encoding invariants.
  task automatic step();
    @(posedge clk);
    #1;
    check("valid_eq_or_gnt", {31'd0, gnt_valid}, {31'd0, |gnt});
    check("gnt_onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
    if (gnt_valid)
      check("gnt_matches_idx", {16'd0, gnt}, {16'd0, 16'h0001 << gnt_idx});
  endtask

  task automatic expect_out(input string tag, input logic [15:0] g, input logic [3:0] i,
                            input logic v, input logic t);
    check({tag, ".gnt"},       {16'd0, gnt},     {16'd0, g});
    check({tag, ".gnt_idx"},   {28'd0, gnt_idx}, {28'd0, i});
    check({tag, ".gnt_valid"}, {31'd0, gnt_valid}, {31'd0, v});
    check({tag, ".timeout"},   {31'd0, timeout}, {31'd0, t});
  endtask

  initial begin
    // reset with all requests pending
    vecs.push_back(mk(0, 1, 16'hFFFF, 16'h0000, 4'd0, 0, 0));
    vecs.push_back(mk(0, 1, 16'hFFFF, 16'h0000, 4'd0, 0, 0));
    vecs.push_back(mk(0, 1, 16'hFFFF, 16'h0000, 4'd0, 0, 0));
    vecs.push_back(mk(1, 1, 16'hFFFF, 16'h0001, 4'd0, 1, 0));
    // idx0 releases, ptr=1; hold limit on requester 3
    vecs.push_back(mk(1, 1, 16'h0008, 16'h0000, 4'd0, 0, 0));
    vecs.push_back(mk(1, 1, 16'h0008, 16'h0008, 4'd3, 1, 0));
    vecs.push_back(mk(1, 1, 16'h0008, 16'h0008, 4'd3, 1, 0));
    vecs.push_back(mk(1, 1, 16'h0008, 16'h0008, 4'd3, 1, 0));
    vecs.push_back(mk(1, 1, 16'h0008, 16'h0008, 4'd3, 1, 0));
    vecs.push_back(mk(1, 1, 16'h0008, 16'h0000, 4'd3, 0, 1));
    vecs.push_back(mk(1, 1, 16'h0008, 16'h0008, 4'd3, 1, 0));
    // release idx3 (ptr=4) -> idx5; early release of idx5 after 2 cycles
    vecs.push_back(mk(1, 1, 16'h0021, 16'h0000, 4'd3, 0, 0));
    vecs.push_back(mk(1, 1, 16'h0021, 16'h0020, 4'd5, 1, 0));
    vecs.push_back(mk(1, 1, 16'h0021, 16'h0020, 4'd5, 1, 0));
    vecs.push_back(mk(1, 1, 16'h0001, 16'h0000, 4'd5, 0, 0));
    // ptr=6 wraps to idx0; drop req[0] in its 2nd cycle -> idx5 next
    vecs.push_back(mk(1, 1, 16'h0001, 16'h0001, 4'd0, 1, 0));
    vecs.push_back(mk(1, 1, 16'h0021, 16'h0001, 4'd0, 1, 0));
    vecs.push_back(mk(1, 1, 16'h0020, 16'h0000, 4'd0, 0, 0));
    vecs.push_back(mk(1, 1, 16'h0020, 16'h0020, 4'd5, 1, 0));
    // idx15 times out, ptr wraps to 0, req 8001 -> idx0
    vecs.push_back(mk(1, 1, 16'h8000, 16'h0000, 4'd5, 0, 0));
    vecs.push_back(mk(1, 1, 16'h8000, 16'h8000, 4'd15, 1, 0));
    vecs.push_back(mk(1, 1, 16'h8000, 16'h8000, 4'd15, 1, 0));
    vecs.push_back(mk(1, 1, 16'h8000, 16'h8000, 4'd15, 1, 0));
    vecs.push_back(mk(1, 1, 16'h8000, 16'h8000, 4'd15, 1, 0));
    vecs.push_back(mk(1, 1, 16'h8001, 16'h0000, 4'd15, 0, 1));
    vecs.push_back(mk(1, 1, 16'h8001, 16'h0001, 4'd0, 1, 0));
    vecs.push_back(mk(1, 1, 16'h8001, 16'h0001, 4'd0, 1, 0));
    vecs.push_back(mk(1, 1, 16'h8001, 16'h0001, 4'd0, 1, 0));
    vecs.push_back(mk(1, 1, 16'h8001, 16'h0001, 4'd0, 1, 0));
    // release on the limit edge: no timeout, ptr=1 -> idx15
    vecs.push_back(mk(1, 1, 16'h8000, 16'h0000, 4'd0, 0, 0));
    vecs.push_back(mk(1, 1, 16'h8000, 16'h8000, 4'd15, 1, 0));
    // en low: release still happens, no new grant until en rises
    vecs.push_back(mk(1, 0, 16'h0100, 16'h0000, 4'd15, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0100, 16'h0000, 4'd15, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0100, 16'h0000, 4'd15, 0, 0));
    vecs.push_back(mk(1, 1, 16'h0100, 16'h0100, 4'd8, 1, 0));
    vecs.push_back(mk(1, 0, 16'h0100, 16'h0100, 4'd8, 1, 0));
    // reset mid-grant, then search restarts from index 0
    vecs.push_back(mk(0, 1, 16'h0100, 16'h0000, 4'd0, 0, 0));
    vecs.push_back(mk(1, 1, 16'h0101, 16'h0001, 4'd0, 1, 0));

    rst_n = 1'b0;
    en    = 1'b0;
    req   = 16'h0000;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n;
      en    = vecs[i].en;
      req   = vecs[i].req;
      step();
      expect_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].idx, vecs[i].valid, vecs[i].tmo);
    end

    // full contention rotation: 0..15 then 0, each MH cycles plus a timeout cycle
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 16'hFFFF;
    step();
    expect_out("rot_reset", 16'h0000, 4'd0, 0, 0);
    rst_n = 1'b1;
    for (int g = 0; g <= 16; g++) begin
      logic [3:0] e;
      e = 4'(g % 16);
      for (int c = 0; c < MH; c++) begin
        step();
        expect_out($sformatf("rot%0d_c%0d", g, c), 16'h0001 << e, e, 1, 0);
      end
      step();
      expect_out($sformatf("rot%0d_dead", g), 16'h0000, e, 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
